// File: rtl/alu_sequential_if.sv
// Request/response bundle for alu_sequential.
// master: the block that issues operations; slave: the ALU itself.
interface alu_sequential_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) ();
  logic                   start;
  logic [3:0]             ALUOperation;
  logic [DATA_WIDTH-1:0]  A;
  logic [DATA_WIDTH-1:0]  B;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   busy;
  logic                   done;
  logic [DATA_WIDTH-1:0]  ALUResult;
  logic                   Zero;
  logic                   Invalid;

  modport master (
    output start, ALUOperation, A, B, shamt,
    input  busy, done, ALUResult, Zero, Invalid
  );

  modport slave (
    input  start, ALUOperation, A, B, shamt,
    output busy, done, ALUResult, Zero, Invalid
  );
endinterface

// File: rtl/alu_sequential.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops, bit-serial shifts
// (one bit per clock) and an optional radix-2 shift-add multiplier.
// Optional feature macro: ALU_MULT_EN (enables code 0111 = MUL; when
// undefined the MULT state and multiplier datapath are not built and 0111
// is reported as an unsupported operation).
module alu_sequential #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  alu_sequential_if.slave  bus
);

  // Counter must hold either a shift amount or DATA_WIDTH multiplier steps.
  localparam int MULT_CW = $clog2(DATA_WIDTH + 1);
  localparam int CNT_W   = (SHAMT_WIDTH > MULT_CW) ? SHAMT_WIDTH : MULT_CW;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
`ifdef ALU_MULT_EN
  localparam logic [3:0] OP_MUL = 4'b0111;
`endif

  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
`ifdef ALU_MULT_EN
    , ST_MULT = 2'd3
`endif
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              op_q, op_d;
  logic [DATA_WIDTH-1:0]   b_q, b_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    zero_q, zero_d;
  logic                    invalid_q, invalid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
`ifdef ALU_MULT_EN
  logic [DATA_WIDTH-1:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [DATA_WIDTH-1:0]   acc_next_s;
`endif
  logic                    accept_s;
  logic [DATA_WIDTH-1:0]   shift_next_s;

  // Result of the operations that complete in the acceptance cycle.
  function automatic logic [DATA_WIDTH-1:0] alu_simple(
    input logic [3:0]            op,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOR:  r = ~(a | b);
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      default: r = DATA_ZERO;
    endcase
    return r;
  endfunction

  // One bit-serial shift step; direction follows the latched opcode.
  function automatic logic [DATA_WIDTH-1:0] shift_step(
    input logic [3:0]            op,
    input logic [DATA_WIDTH-1:0] v
  );
    logic [DATA_WIDTH-1:0] r;
    if (op == OP_SRL) begin
      r = v >> 1;
    end else begin
      r = v << 1;
    end
    return r;
  endfunction

  // A new request is taken only when no iterative operation is running.
  assign accept_s = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  assign shift_next_s = shift_step(op_q, b_q);
`ifdef ALU_MULT_EN
  assign acc_next_s = b_q[0] ? (acc_q + a_q) : acc_q;
`endif

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= 4'b0000;
      b_q       <= DATA_ZERO;
      cnt_q     <= {CNT_W{1'b0}};
      result_q  <= DATA_ZERO;
      zero_q    <= 1'b1;
      invalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef ALU_MULT_EN
      a_q       <= DATA_ZERO;
      acc_q     <= DATA_ZERO;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      invalid_q <= invalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef ALU_MULT_EN
      a_q       <= a_d;
      acc_q     <= acc_d;
`endif
    end
  end

  // Next-state logic of the control FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          case (bus.ALUOperation)
            OP_SLL, OP_SRL: begin
              if (bus.shamt == {SHAMT_WIDTH{1'b0}}) begin
                state_d = ST_DONE;
              end else begin
                state_d = ST_SHIFT;
              end
            end
`ifdef ALU_MULT_EN
            OP_MUL:  state_d = ST_MULT;
`endif
            default: state_d = ST_DONE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
`ifdef ALU_MULT_EN
      ST_MULT: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_MULT;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered output values for the next cycle.
  always_comb begin
    op_d      = op_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    invalid_d = invalid_q;
`ifdef ALU_MULT_EN
    a_d       = a_q;
    acc_d     = acc_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          op_d = bus.ALUOperation;
          case (bus.ALUOperation)
            OP_AND, OP_OR, OP_NOR, OP_ADD, OP_SUB: begin
              result_d  = alu_simple(bus.ALUOperation, bus.A, bus.B);
              invalid_d = 1'b0;
            end
            OP_SLL, OP_SRL: begin
              if (bus.shamt == {SHAMT_WIDTH{1'b0}}) begin
                result_d  = bus.B;
                invalid_d = 1'b0;
              end else begin
                b_d   = bus.B;
                cnt_d = CNT_W'(bus.shamt);
              end
            end
`ifdef ALU_MULT_EN
            OP_MUL: begin
              a_d   = bus.A;
              b_d   = bus.B;
              acc_d = DATA_ZERO;
              cnt_d = CNT_W'(DATA_WIDTH);
            end
`endif
            default: begin
              result_d  = DATA_ZERO;
              invalid_d = 1'b1;
            end
          endcase
        end else begin
          op_d = op_q;
        end
      end
      ST_SHIFT: begin
        b_d   = shift_next_s;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          result_d  = shift_next_s;
          invalid_d = 1'b0;
        end else begin
          result_d  = result_q;
        end
      end
`ifdef ALU_MULT_EN
      ST_MULT: begin
        acc_d = acc_next_s;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          result_d  = acc_next_s;
          invalid_d = 1'b0;
        end else begin
          result_d  = result_q;
        end
      end
`endif
      default: begin
        cnt_d = {CNT_W{1'b0}};
      end
    endcase
  end

  // Flags derived from the next state and next result.
  always_comb begin
    zero_d = (result_d == DATA_ZERO);
    done_d = (state_d == ST_DONE);
`ifdef ALU_MULT_EN
    busy_d = (state_d == ST_SHIFT) || (state_d == ST_MULT);
`else
    busy_d = (state_d == ST_SHIFT);
`endif
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ALUResult = result_q;
  assign bus.Zero      = zero_q;
  assign bus.Invalid   = invalid_q;

endmodule

// File: tb/tb_alu_sequential.sv
// Directed table-driven bench for alu_sequential plus hand-written
// sequences for ignored start, mid-operation reset and back-to-back use.
module tb_alu_sequential;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_sequential_if #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) bus_if ();

  alu_sequential #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [31:0] res;
    logic        zero;
    logic        inv;
    int          lat;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh);
    @(negedge clk);
    bus_if.ALUOperation = op;
    bus_if.A = a;
    bus_if.B = b;
    bus_if.shamt = sh;
    bus_if.start = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus_if.done !== 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int busy_cnt;
    int done_seen;
    logic hold_ok;
    logic [31:0] prev_res;

    vecs[0]  = '{4'b0011, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0, 1'b0, 0};
    vecs[1]  = '{4'b0100, 32'd5,        32'd5,        5'd0,  32'h00000000, 1'b1, 1'b0, 0};
    vecs[2]  = '{4'b0000, 32'hFF00FF00, 32'h0FF00FF0, 5'd0,  32'h0F000F00, 1'b0, 1'b0, 0};
    vecs[3]  = '{4'b0001, 32'hF0F0F0F0, 32'h0F0F0F00, 5'd0,  32'hFFFFFFF0, 1'b0, 1'b0, 0};
    vecs[4]  = '{4'b0010, 32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 0};
    vecs[5]  = '{4'b0010, 32'hFFFF0000, 32'h0000FFFF, 5'd0,  32'h00000000, 1'b1, 1'b0, 0};
    vecs[6]  = '{4'b0100, 32'h00000000, 32'h00000001, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 0};
    vecs[7]  = '{4'b0011, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b1, 1'b0, 0};
    vecs[8]  = '{4'b1000, 32'h12345678, 32'h9ABCDEF0, 5'd3,  32'h00000000, 1'b1, 1'b1, 0};
    vecs[9]  = '{4'b0101, 32'h00000000, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 1'b0, 31};
    vecs[10] = '{4'b0110, 32'h00000000, 32'hF0000000, 5'd4,  32'h0F000000, 1'b0, 1'b0, 4};
    vecs[11] = '{4'b0101, 32'h00000000, 32'h00000003, 5'd0,  32'h00000003, 1'b0, 1'b0, 0};
    vecs[12] = '{4'b0110, 32'h00000000, 32'h00000001, 5'd1,  32'h00000000, 1'b1, 1'b0, 1};
    vecs[13] = '{4'b0101, 32'h00000000, 32'hA5A5A5A5, 5'd1,  32'h4B4B4B4A, 1'b0, 1'b0, 1};
`ifdef ALU_MULT_EN
    vecs[14] = '{4'b0111, 32'hFFFFFFFF, 32'h00000003, 5'd0,  32'hFFFFFFFD, 1'b0, 1'b0, 32};
    vecs[15] = '{4'b0111, 32'h00000006, 32'h00000007, 5'd0,  32'h0000002A, 1'b0, 1'b0, 32};
`else
    vecs[14] = '{4'b0111, 32'hFFFFFFFF, 32'h00000003, 5'd0,  32'h00000000, 1'b1, 1'b1, 0};
    vecs[15] = '{4'b0111, 32'h00000006, 32'h00000007, 5'd0,  32'h00000000, 1'b1, 1'b1, 0};
`endif
    vecs[16] = '{4'b1111, 32'h00000001, 32'h00000001, 5'd1,  32'h00000000, 1'b1, 1'b1, 0};

    // Reset state
    reset = 1'b1;
    bus_if.start = 1'b0;
    bus_if.ALUOperation = 4'b0000;
    bus_if.A = 32'h0;
    bus_if.B = 32'h0;
    bus_if.shamt = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy",    {31'b0, bus_if.busy},    32'd0);
    check("reset_done",    {31'b0, bus_if.done},    32'd0);
    check("reset_result",  bus_if.ALUResult,        32'h0);
    check("reset_zero",    {31'b0, bus_if.Zero},    32'd1);
    check("reset_invalid", {31'b0, bus_if.Invalid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Vector table
    for (int i = 0; i < NVEC; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].shamt);
      check($sformatf("v%0d_busy_at_e0", i), {31'b0, bus_if.busy},
            (vecs[i].lat > 0) ? 32'd1 : 32'd0);
      wait_done(cyc);
      check($sformatf("v%0d_latency", i), 32'(cyc), 32'(vecs[i].lat));
      check($sformatf("v%0d_result", i),  bus_if.ALUResult, vecs[i].res);
      check($sformatf("v%0d_zero", i),    {31'b0, bus_if.Zero},    {31'b0, vecs[i].zero});
      check($sformatf("v%0d_invalid", i), {31'b0, bus_if.Invalid}, {31'b0, vecs[i].inv});
      check($sformatf("v%0d_busy_done", i), {31'b0, bus_if.busy}, 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_pulse", i), {31'b0, bus_if.done}, 32'd0);
    end

    // SLL by 31 with an ignored start pulse at E0+10 and changing inputs
    prev_res = vecs[NVEC-1].res;
    launch(4'b0101, 32'h0, 32'h00000001, 5'd31);
    cyc = 0;
    busy_cnt = 0;
    hold_ok = 1'b1;
    while (bus_if.done !== 1'b1 && cyc < 100) begin
      if (bus_if.busy === 1'b1) busy_cnt++;
      if (bus_if.ALUResult !== prev_res) hold_ok = 1'b0;
      if (cyc == 9) begin
        bus_if.start = 1'b1;
        bus_if.ALUOperation = 4'b0011;
        bus_if.A = 32'h1;
        bus_if.B = 32'h1;
        bus_if.shamt = 5'd2;
      end
      if (cyc == 10) bus_if.start = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("sll31_latency",   32'(cyc), 32'd31);
    check("sll31_busy_cnt",  32'(busy_cnt), 32'd31);
    check("sll31_hold",      {31'b0, hold_ok}, 32'd1);
    check("sll31_result",    bus_if.ALUResult, 32'h80000000);
    check("sll31_zero",      {31'b0, bus_if.Zero}, 32'd0);
    @(posedge clk);
    #1;
    check("sll31_done_pulse", {31'b0, bus_if.done}, 32'd0);

    // Reset in the middle of a long SRL
    launch(4'b0110, 32'h0, 32'hF0000000, 5'd20);
    repeat (5) @(posedge clk);
    check("rst_busy_before", {31'b0, bus_if.busy}, 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check("rst_busy",    {31'b0, bus_if.busy},    32'd0);
    check("rst_done",    {31'b0, bus_if.done},    32'd0);
    check("rst_result",  bus_if.ALUResult,        32'h0);
    check("rst_zero",    {31'b0, bus_if.Zero},    32'd1);
    check("rst_invalid", {31'b0, bus_if.Invalid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (bus_if.done === 1'b1) done_seen++;
    end
    check("rst_no_done", 32'(done_seen), 32'd0);

    // Start accepted at the first edge after reset release
    @(negedge clk);
    reset = 1'b1;
    bus_if.ALUOperation = 4'b0011;
    bus_if.A = 32'd2;
    bus_if.B = 32'd3;
    bus_if.start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    check("post_rst_done",   {31'b0, bus_if.done}, 32'd1);
    check("post_rst_result", bus_if.ALUResult, 32'd5);

    // Back-to-back: ADD, then AND accepted in its DONE cycle
    @(negedge clk);
    bus_if.ALUOperation = 4'b0011;
    bus_if.A = 32'h7FFFFFFF;
    bus_if.B = 32'h00000001;
    bus_if.start = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_done1",   {31'b0, bus_if.done}, 32'd1);
    check("b2b_result1", bus_if.ALUResult, 32'h80000000);
    check("b2b_busy1",   {31'b0, bus_if.busy}, 32'd0);
    bus_if.ALUOperation = 4'b0000;
    bus_if.A = 32'hFF00FF00;
    bus_if.B = 32'h0FF00FF0;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    check("b2b_done2",   {31'b0, bus_if.done}, 32'd1);
    check("b2b_result2", bus_if.ALUResult, 32'h0F000F00);
    check("b2b_zero2",   {31'b0, bus_if.Zero}, 32'd0);
    @(posedge clk);
    #1;
    check("b2b_done3",   {31'b0, bus_if.done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_sequential.md
ALU_SEQUENTIAL -- requirements
Module: alu_sequential

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter SHAMT_WIDTH, default 5: shift-amount width in bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request strobe; sampled on the rising edge.
REQ-006 ALUOperation  input  4  operation code from the ALU control stage.
REQ-007 A  input  DATA_WIDTH  operand rs.
REQ-008 B  input  DATA_WIDTH  operand rt; this is also the shift source.
REQ-009 shamt  input  SHAMT_WIDTH  shift amount.
REQ-010 busy  output  1  high while an iterative operation is in progress.
REQ-011 done  output  1  one-cycle pulse indicating the result is valid.
REQ-012 ALUResult  output  DATA_WIDTH  registered result.
REQ-013 Zero  output  1  registered flag, equal to (ALUResult == 0).
REQ-014 Invalid  output  1  registered flag indicating an unsupported ALUOperation.

Function
REQ-015 Codes and operations:
- 0000: A AND B
- 0001: A OR B
- 0010: NOR(A, B)
- 0011: A+B
- 0100: A-B
- 0101: B<<shamt
- 0110: B>>shamt (logical)
- 0111: A*B, low DATA_WIDTH bits (only with the macro in REQ-031)
REQ-016 ADD, SUB and MUL wrap modulo 2^DATA_WIDTH; no overflow indication is produced.
REQ-017 FSM states:
- IDLE
- SHIFT
- MULT
- DONE
REQ-018 Acceptance: start=1 at edge E0 in IDLE or DONE latches A, B, shamt and ALUOperation.
REQ-019 Latency L is counted in edges after E0.
- done is high from edge E0+L until edge E0+L+1.
- ALUResult, Zero and Invalid update at edge E0+L.
REQ-020 Codes 0000-0100, and shifts with shamt=0: L=0; the FSM moves directly to DONE at E0.
REQ-021 Shifts with shamt=k>0:
- L=k; the FSM is in SHIFT for k cycles.
- The operand shifts one bit per edge at E1..Ek.
- The FSM moves to DONE at Ek.
REQ-022 MUL:
- L=DATA_WIDTH; the FSM is in MULT.
- Radix-2 shift-add, one multiplier bit per edge.
- The FSM moves to DONE at E0+DATA_WIDTH.
REQ-023 Unsupported codes:
- L=0, ALUResult=0, Zero=1, Invalid=1.
- Invalid is 0 for every supported code.
REQ-024 busy is 1 exactly while the FSM is in SHIFT or MULT; it is 0 in IDLE and in DONE.
REQ-025 start while busy=1 is ignored, and the latched operands are unaffected.
REQ-026 DONE lasts one cycle and returns to IDLE unless start=1, which gives back-to-back acceptance.
REQ-027 ALUResult, Zero and Invalid hold their last values until the next completion.
- They do not change during SHIFT or MULT.
REQ-028 Input changes after E0 do not affect an operation in progress.

Reset
REQ-029 reset=1, including mid-operation, immediately forces:
- state IDLE
- busy=0, done=0, ALUResult=0, Zero=1, Invalid=0
- iteration counter and working registers cleared
REQ-030 An operation interrupted by reset produces no done pulse.
- start is accepted at the first rising edge with reset=0.

Configuration
REQ-031 Macro ALU_MULT_EN.
- Defined: code 0111 performs MUL per REQ-022.
- Undefined: the MULT state and the multiplier datapath are absent, and code 0111 is handled as unsupported per REQ-023.

Verification
REQ-032 ADD: start with op=0011, A=32'h7FFFFFFF, B=1 -> next cycle done=1, ALUResult=32'h80000000, Zero=0, busy never high.
REQ-033 SUB: op=0100, A=B=32'd5 -> L=0, ALUResult=0, Zero=1, Invalid=0.
REQ-034 SLL: op=0101, B=32'h1, shamt=31 -> busy high for 31 cycles, done at E0+31, ALUResult=32'h80000000; a start pulse at E0+10 is ignored.
REQ-035 MUL: with ALU_MULT_EN, op=0111, A=32'hFFFFFFFF, B=3 -> done at E0+32, ALUResult=32'hFFFFFFFD; without the macro -> done at E0, ALUResult=0, Invalid=1.
REQ-036 Reset: op=0110, B=32'hF0000000, shamt=20, reset asserted at E0+5 -> outputs return to reset values immediately and no done pulse is seen.
REQ-037 Back-to-back: start in the DONE cycle of REQ-032 with op=0000, A=32'hFF00FF00, B=32'h0FF00FF0 -> done=1 in two consecutive cycles, second ALUResult=32'h0F000F00.
